ddr4_axi_mem_tester: RTL



---
 rtl/ddr4_axi_mem_tester_if.sv | 48 ++++
 rtl/ddr4_axi_mem_tester.sv | 237 +++++++++++++++++++++++
 2 files changed

// File: rtl/ddr4_axi_mem_tester_if.sv
// AXI4 master-to-slave bus used by the DDR4 memory tester (IDs omitted, all zero).
// The master modport drives requests and write data; the slave modport drives responses.
interface ddr4_axi_mem_tester_if #(
  parameter int AXI_DATA_W = 128,
  parameter int AXI_ADDR_W = 64
);
  logic [AXI_ADDR_W-1:0]   awaddr;
  logic [7:0]              awlen;
  logic [2:0]              awsize;
  logic [1:0]              awburst;
  logic                    awvalid;
  logic                    awready;
  logic [AXI_DATA_W-1:0]   wdata;
  logic [AXI_DATA_W/8-1:0] wstrb;
  logic                    wlast;
  logic                    wvalid;
  logic                    wready;
  logic [1:0]              bresp;
  logic                    bvalid;
  logic                    bready;
  logic [AXI_ADDR_W-1:0]   araddr;
  logic [7:0]              arlen;
  logic [2:0]              arsize;
  logic [1:0]              arburst;
  logic                    arvalid;
  logic                    arready;
  logic [AXI_DATA_W-1:0]   rdata;
  logic [1:0]              rresp;
  logic                    rlast;
  logic                    rvalid;
  logic                    rready;

  modport master (
    output awaddr, awlen, awsize, awburst, awvalid, input awready,
    output wdata, wstrb, wlast, wvalid, input wready,
    input  bresp, bvalid, output bready,
    output araddr, arlen, arsize, arburst, arvalid, input arready,
    input  rdata, rresp, rlast, rvalid, output rready
  );

  modport slave (
    input  awaddr, awlen, awsize, awburst, awvalid, output awready,
    input  wdata, wstrb, wlast, wvalid, output wready,
    output bresp, bvalid, input bready,
    input  araddr, arlen, arsize, arburst, arvalid, output arready,
    output rdata, rresp, rlast, rvalid, input rready
  );
endinterface

// File: rtl/ddr4_axi_mem_tester.sv
// AXI4 memory-test master: writes an address-derived pattern over num_bursts bursts,
// reads it back, and counts erroneous beats/responses. One burst outstanding at a time.
module ddr4_axi_mem_tester #(
  parameter int AXI_DATA_W = 128,
  parameter int AXI_ADDR_W = 64,
  parameter int BURST_LEN  = 16
) (
  input  logic                  PCIE_user_Clk,
  input  logic                  PCIE_user_Rst_n,
  input  logic                  start,
  input  logic [AXI_ADDR_W-1:0] base_addr,
  input  logic [31:0]           num_bursts,
  input  logic [31:0]           seed,
  output logic                  busy,
  output logic                  done,
  output logic                  pass,
  output logic [31:0]           err_count,
  output logic [AXI_ADDR_W-1:0] first_err_addr,
  ddr4_axi_mem_tester_if.master m_axi
);

  localparam int BEAT_BYTES = AXI_DATA_W / 8;
  localparam int LANES      = AXI_DATA_W / 32;
  localparam logic [AXI_ADDR_W-1:0] BEAT_INC    = AXI_ADDR_W'(BEAT_BYTES);
  localparam logic [AXI_ADDR_W-1:0] BURST_BYTES = AXI_ADDR_W'(BURST_LEN * BEAT_BYTES);
  localparam logic [7:0]            AXLEN       = 8'(BURST_LEN - 1);
  localparam logic [2:0]            AXSIZE      = 3'($clog2(BEAT_BYTES));
  localparam logic [8:0]            LAST_BEAT   = 9'(BURST_LEN - 1);

  typedef enum logic [2:0] {
    IDLE, WR_ADDR, WR_DATA, WR_RESP, RD_ADDR, RD_DATA, DONE
  } state_t;

  function automatic logic [AXI_DATA_W-1:0] beat_pattern(input logic [AXI_ADDR_W-1:0] a,
                                                         input logic [31:0] s);
    logic [AXI_DATA_W-1:0] d;
    d = '0;
    for (int i = 0; i < LANES; i++) d[32*i +: 32] = (a[31:0] + 32'(4 * i)) ^ s;
    return d;
  endfunction

  function automatic logic [31:0] sat_inc32(input logic [31:0] c);
    return (c == 32'hFFFF_FFFF) ? c : c + 32'd1;
  endfunction

  state_t                state;
  logic [8:0]            beat_cnt;
  logic [31:0]           burst_cnt;
  logic [31:0]           num_q;
  logic [31:0]           seed_q;
  logic [AXI_ADDR_W-1:0] base_q;
  logic [AXI_ADDR_W-1:0] burst_addr;
  logic [AXI_ADDR_W-1:0] beat_addr;
  logic                  fin_p1;
  logic                  vld_p1;
  logic                  bad_p1;
  logic [AXI_ADDR_W-1:0] addr_p1;

  logic start_ok, aw_hs, w_hs, b_hs, ar_hs, r_hs, burst_last, err_evt;
  logic [AXI_ADDR_W-1:0] err_addr;

  assign start_ok   = start && !busy;
  assign aw_hs      = m_axi.awvalid && m_axi.awready;
  assign w_hs       = m_axi.wvalid && m_axi.wready;
  assign b_hs       = m_axi.bvalid && m_axi.bready;
  assign ar_hs      = m_axi.arvalid && m_axi.arready;
  assign r_hs       = m_axi.rvalid && m_axi.rready;
  assign burst_last = (burst_cnt == num_q - 32'd1);
  // Write-response errors report the burst address; read errors come from the compare stage.
  assign err_evt    = (vld_p1 && bad_p1) || (b_hs && m_axi.bresp != 2'b00);
  assign err_addr   = b_hs ? burst_addr : addr_p1;

  assign m_axi.awlen   = AXLEN;
  assign m_axi.awsize  = AXSIZE;
  assign m_axi.awburst = 2'b01;
  assign m_axi.wstrb   = '1;
  assign m_axi.arlen   = AXLEN;
  assign m_axi.arsize  = AXSIZE;
  assign m_axi.arburst = 2'b01;

  // Address/data path: advances only on handshakes, so payload is stable under stalls.
  always_ff @(posedge PCIE_user_Clk) begin
    if (start_ok) begin
      base_q       <= base_addr;
      seed_q       <= seed;
      burst_addr   <= base_addr;
      m_axi.awaddr <= base_addr;
    end
    if (aw_hs) begin
      beat_addr   <= burst_addr;
      m_axi.wdata <= beat_pattern(burst_addr, seed_q);
    end
    if (w_hs) begin
      beat_addr   <= beat_addr + BEAT_INC;
      m_axi.wdata <= beat_pattern(beat_addr + BEAT_INC, seed_q);
    end
    if (b_hs) begin
      if (burst_last) begin
        burst_addr   <= base_q;
        m_axi.araddr <= base_q;
      end else begin
        burst_addr   <= burst_addr + BURST_BYTES;
        m_axi.awaddr <= burst_addr + BURST_BYTES;
      end
    end
    if (ar_hs) beat_addr <= burst_addr;
    // stage p1: registered read compare
    if (r_hs) begin
      bad_p1    <= (m_axi.rdata != beat_pattern(beat_addr, seed_q)) ||
                   (m_axi.rresp != 2'b00) ||
                   (m_axi.rlast != (beat_cnt == LAST_BEAT));
      addr_p1   <= beat_addr;
      beat_addr <= beat_addr + BEAT_INC;
      if (m_axi.rlast && !burst_last) begin
        burst_addr   <= burst_addr + BURST_BYTES;
        m_axi.araddr <= burst_addr + BURST_BYTES;
      end
    end
  end

  always_ff @(posedge PCIE_user_Clk or negedge PCIE_user_Rst_n) begin
    if (!PCIE_user_Rst_n) begin
      state          <= IDLE;
      m_axi.awvalid  <= 1'b0;
      m_axi.wvalid   <= 1'b0;
      m_axi.wlast    <= 1'b0;
      m_axi.bready   <= 1'b0;
      m_axi.arvalid  <= 1'b0;
      m_axi.rready   <= 1'b0;
      busy           <= 1'b0;
      done           <= 1'b0;
      pass           <= 1'b0;
      err_count      <= '0;
      first_err_addr <= '0;
      beat_cnt       <= '0;
      burst_cnt      <= '0;
      num_q          <= '0;
      fin_p1         <= 1'b0;
      vld_p1         <= 1'b0;
    end else begin
      vld_p1 <= r_hs;
      fin_p1 <= 1'b0;
      if (err_evt) begin
        err_count <= sat_inc32(err_count);
        if (err_count == '0) first_err_addr <= err_addr;
      end
      // stage p2: final status lands together with the last beat's error
      if (fin_p1) begin
        done <= 1'b1;
        busy <= 1'b0;
        pass <= (err_count == '0) && !err_evt;
      end
      case (state)
        IDLE, DONE: begin
          if (start_ok) begin
            busy           <= 1'b1;
            done           <= 1'b0;
            pass           <= 1'b0;
            err_count      <= '0;
            first_err_addr <= '0;
            num_q          <= num_bursts;
            burst_cnt      <= '0;
            if (num_bursts == '0) begin
              state  <= DONE;
              fin_p1 <= 1'b1;
            end else begin
              state         <= WR_ADDR;
              m_axi.awvalid <= 1'b1;
            end
          end
        end
        WR_ADDR: begin
          if (aw_hs) begin
            m_axi.awvalid <= 1'b0;
            m_axi.wvalid  <= 1'b1;
            m_axi.wlast   <= (BURST_LEN == 1);
            beat_cnt      <= '0;
            state         <= WR_DATA;
          end
        end
        WR_DATA: begin
          if (w_hs) begin
            beat_cnt <= beat_cnt + 9'd1;
            if (m_axi.wlast) begin
              m_axi.wvalid <= 1'b0;
              m_axi.wlast  <= 1'b0;
              m_axi.bready <= 1'b1;
              state        <= WR_RESP;
            end else begin
              m_axi.wlast <= (beat_cnt + 9'd1 == LAST_BEAT);
            end
          end
        end
        WR_RESP: begin
          if (b_hs) begin
            m_axi.bready <= 1'b0;
            if (burst_last) begin
              burst_cnt     <= '0;
              m_axi.arvalid <= 1'b1;
              state         <= RD_ADDR;
            end else begin
              burst_cnt     <= burst_cnt + 32'd1;
              m_axi.awvalid <= 1'b1;
              state         <= WR_ADDR;
            end
          end
        end
        RD_ADDR: begin
          if (ar_hs) begin
            m_axi.arvalid <= 1'b0;
            m_axi.rready  <= 1'b1;
            beat_cnt      <= '0;
            state         <= RD_DATA;
          end
        end
        RD_DATA: begin
          if (r_hs) begin
            beat_cnt <= beat_cnt + 9'd1;
            if (m_axi.rlast) begin
              m_axi.rready <= 1'b0;
              if (burst_last) begin
                state  <= DONE;
                fin_p1 <= 1'b1;
              end else begin
                burst_cnt     <= burst_cnt + 32'd1;
                m_axi.arvalid <= 1'b1;
                state         <= RD_ADDR;
              end
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
